uart_tx_arbiter: RTL

Shares the single `uart_tx` serializer between up to `NUM_REQ` byte producers: the parse, generate, table and calculate printers. Each producer requests ownership for a whole message. The arbiter grants round-robin, forwards only the owner's bytes with a registered stage, and presents per-requester busy so non-owners stall cleanly. It replaces the mode-keyed combinational TX mux in `sys_top`, so a message in flight is never cut off or interleaved on a mode change.

---
 rtl/uart_tx_arb_pkg.sv | 21 ++
 rtl/uart_tx_arbiter_rr_picker.sv | 34 +++
 rtl/uart_tx_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/uart_tx_arb_pkg.sv
// Shared types and defaults for the UART TX arbiter: FSM state encoding,
// default parameter values and requester index assignments.
package uart_tx_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DRAIN = 2'd2,
        GAP   = 2'd3
    } arb_state_t;

    localparam int DEF_NUM_REQ     = 4;
    localparam int DEF_GAP_CYC     = 16;
    localparam int DEF_TIMEOUT_CYC = 25_000_000;

    localparam int REQ_PARSE = 0;
    localparam int REQ_GEN   = 1;
    localparam int REQ_TABLE = 2;
    localparam int REQ_CALC  = 3;

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: first unmasked request at or after rr_ptr,
// wrapping, returned one-hot.
module rr_picker
    import uart_tx_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    input  logic [NUM_REQ-1:0] mask,
    output logic [NUM_REQ-1:0] pick,
    output logic               any
);

    logic [NUM_REQ-1:0] eligible;
    logic [PTR_W-1:0]   idx;

    // Scan from farthest to nearest so the nearest eligible slot wins.
    always_comb begin
        eligible = req & ~mask;
        any      = |eligible;
        pick     = '0;
        idx      = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = PTR_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (eligible[idx]) begin
                pick      = '0;
                pick[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-level round-robin owner of the shared uart_tx serializer.
// Optional owner-inactivity timeout: define UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int GAP_CYC     = DEF_GAP_CYC,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   src_tx_en,
    input  logic [8*NUM_REQ-1:0] src_tx_data,
    output logic [NUM_REQ-1:0]   src_tx_busy,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 uart_tx_en,
    output logic [7:0]           uart_tx_data,
    input  logic                 uart_tx_busy,
    output logic                 arb_timeout
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int GAP_W = $clog2(GAP_CYC + 1);

    arb_state_t         state, state_nxt;
    logic [PTR_W-1:0]   owner;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   next_ptr;
    logic [PTR_W-1:0]   pick_idx;
    logic [NUM_REQ-1:0] pick;
    logic [NUM_REQ-1:0] mask;
    logic               any;
    logic               pend;
    logic [GAP_W-1:0]   gap_cnt;
    logic               accept;
    logic               drain_done;
    logic               timeout_hit;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .req    (req),
        .rr_ptr (rr_ptr),
        .mask   (mask),
        .pick   (pick),
        .any    (any)
    );

    // pend covers the gap between our strobe and uart_tx raising its busy.
    assign src_tx_busy = ~grant | {NUM_REQ{uart_tx_busy | pend}};
    assign accept      = (state == GRANT) && src_tx_en[owner] && !src_tx_busy[owner];
    assign drain_done  = !pend && !uart_tx_busy;
    assign next_ptr    = (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) pick_idx = PTR_W'(i);
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (any) state_nxt = GRANT;
            GRANT:   if (!req[owner] || timeout_hit) state_nxt = DRAIN;
            DRAIN:   if (drain_done) state_nxt = GAP;
            GAP:     if (gap_cnt <= GAP_W'(1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            grant        <= '0;
            owner        <= '0;
            rr_ptr       <= '0;
            pend         <= 1'b0;
            gap_cnt      <= '0;
            uart_tx_en   <= 1'b0;
            uart_tx_data <= 8'h00;
        end else begin
            state      <= state_nxt;
            uart_tx_en <= accept;
            if (accept) begin
                uart_tx_data <= src_tx_data[8*owner +: 8];
                pend         <= 1'b1;
            end else if (uart_tx_busy) begin
                pend <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (any) begin
                        grant <= pick;
                        owner <= pick_idx;
                    end
                end
                DRAIN: begin
                    if (drain_done) begin
                        grant   <= '0;
                        rr_ptr  <= next_ptr;
                        gap_cnt <= GAP_W'(GAP_CYC);
                    end
                end
                GAP: begin
                    if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] to_cnt;
    logic            idle_cyc;

    assign idle_cyc    = (state == GRANT) && !accept && !pend && !uart_tx_busy;
    assign timeout_hit = idle_cyc && (to_cnt == TO_W'(TIMEOUT_CYC - 1));

    // A revoked owner stays masked until its req has been seen low once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt      <= '0;
            mask        <= '0;
            arb_timeout <= 1'b0;
        end else begin
            arb_timeout <= timeout_hit;
            mask        <= (mask & req) | ({NUM_REQ{timeout_hit}} & grant);
            if (state != GRANT || accept || timeout_hit) begin
                to_cnt <= '0;
            end else if (idle_cyc) begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign mask        = '0;
    assign arb_timeout = 1'b0;
`endif

endmodule
